// File: rtl/mem_noc_arbiter_4to1_pkg.sv
// Shared types for the 4-to-1 memory request arbiter: request/response
// payloads, arbiter FSM states and the 2-bit master id.
package mem_noc_arbiter_4to1_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  typedef enum logic {
    ARB_REQ  = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_t;

  typedef logic [1:0] mst_id_t;

  localparam int      N_MST      = 4;
  // Pointer starts at the last master so mn0 is searched first after reset.
  localparam mst_id_t RR_PTR_RST = 2'd3;

endpackage

// File: rtl/mem_noc_arbiter_4to1_rr_arbiter_4.sv
// Combinational 4-way selector: round-robin search starting one above ptr,
// or fixed priority (lowest index wins) when rr_en is low.
module rr_arbiter_4
  import mem_noc_arbiter_4to1_pkg::*;
(
  input  logic [3:0] req,
  input  mst_id_t    ptr,
  input  logic       rr_en,
  output mst_id_t    sel,
  output logic       any_vld
);

  logic    found;
  mst_id_t cand;

  // Pick the first requesting master in the active search order.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    if (rr_en) begin
      // Offsets 1..4 wrap mod 4, so the previous winner is searched last.
      for (int i = 1; i <= N_MST; i++) begin
        cand = ptr + mst_id_t'(i);
        if (!found && req[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_MST; i++) begin
        if (!found && req[i]) begin
          sel   = mst_id_t'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign any_vld = |req;

endmodule

// File: rtl/mem_noc_arbiter_4to1.sv
// Merges four memory-request initiators onto one slave port with a single
// outstanding transaction, and steers each response back to its issuer.
module mem_noc_arbiter_4to1
  import mem_noc_arbiter_4to1_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter bit B2B_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      mn0_req_valid,
  output logic      mn0_req_ready,
  input  mem_req_t  mn0_req,
  output logic      mn0_resp_valid,
  input  logic      mn0_resp_ready,
  output mem_resp_t mn0_resp,
  input  logic      mn1_req_valid,
  output logic      mn1_req_ready,
  input  mem_req_t  mn1_req,
  output logic      mn1_resp_valid,
  input  logic      mn1_resp_ready,
  output mem_resp_t mn1_resp,
  input  logic      mn2_req_valid,
  output logic      mn2_req_ready,
  input  mem_req_t  mn2_req,
  output logic      mn2_resp_valid,
  input  logic      mn2_resp_ready,
  output mem_resp_t mn2_resp,
  input  logic      mn3_req_valid,
  output logic      mn3_req_ready,
  input  mem_req_t  mn3_req,
  output logic      mn3_resp_valid,
  input  logic      mn3_resp_ready,
  output mem_resp_t mn3_resp,
  output logic      sn_req_valid,
  input  logic      sn_req_ready,
  output mem_req_t  sn_req,
  input  logic      sn_resp_valid,
  output logic      sn_resp_ready,
  input  mem_resp_t sn_resp
);

  arb_state_t state_reg, state_next;
  mst_id_t    rr_ptr_reg, lock_id_reg, gnt_id_reg;
  logic       lock_vld_reg;

  logic [3:0] req_valid_vec, resp_ready_vec;
  logic [3:0] req_ready_vec, resp_valid_vec;
  mem_req_t   req_pay [N_MST];

  mst_id_t arb_sel, sel;
  logic    any_vld, sel_vld;
  logic    arb_en, req_hs, resp_hs;

  assign req_valid_vec  = {mn3_req_valid, mn2_req_valid, mn1_req_valid, mn0_req_valid};
  assign resp_ready_vec = {mn3_resp_ready, mn2_resp_ready, mn1_resp_ready, mn0_resp_ready};
  assign req_pay[0] = mn0_req;
  assign req_pay[1] = mn1_req;
  assign req_pay[2] = mn2_req;
  assign req_pay[3] = mn3_req;

  rr_arbiter_4 u_rr_arbiter_4 (
    .req     (req_valid_vec),
    .ptr     (rr_ptr_reg),
    .rr_en   (RR_EN),
    .sel     (arb_sel),
    .any_vld (any_vld)
  );

  // A stalled request keeps its master until the slave accepts it.
  assign sel     = lock_vld_reg ? lock_id_reg : arb_sel;
  assign sel_vld = lock_vld_reg ? req_valid_vec[lock_id_reg] : any_vld;

  // The response handshake is only meaningful while a transaction is open.
  assign resp_hs = (state_reg == ARB_RESP) && sn_resp_valid && resp_ready_vec[gnt_id_reg];

  // Reset gates arbitration so no valid/ready leaks out while rstn is low.
  assign arb_en = rstn && ((state_reg == ARB_REQ) || (resp_hs && B2B_EN));

  assign sn_req_valid = arb_en && sel_vld;
  assign sn_req       = req_pay[sel];
  assign req_hs       = sn_req_valid && sn_req_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ARB_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: a new grant always opens a transaction, even in the
  // cycle that closes the previous one.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_REQ: begin
        if (req_hs) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        if (resp_hs && !req_hs) state_next = ARB_REQ;
      end
      default: state_next = ARB_REQ;
    endcase
  end

  // FSM outputs: request ready to the selected master, response steering.
  always_comb begin
    req_ready_vec  = '0;
    resp_valid_vec = '0;
    sn_resp_ready  = 1'b0;
    if (arb_en) req_ready_vec[sel] = sn_req_ready;
    if (state_reg == ARB_RESP) begin
      resp_valid_vec[gnt_id_reg] = sn_resp_valid;
      sn_resp_ready              = resp_ready_vec[gnt_id_reg];
    end
  end

  // Grant bookkeeping: remember the winner, advance the pointer, and lock a
  // selection the slave has not yet accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_reg   <= RR_PTR_RST;
      lock_vld_reg <= 1'b0;
      lock_id_reg  <= '0;
      gnt_id_reg   <= '0;
    end else if (req_hs) begin
      gnt_id_reg   <= sel;
      rr_ptr_reg   <= sel;
      lock_vld_reg <= 1'b0;
    end else if (sn_req_valid) begin
      lock_vld_reg <= 1'b1;
      lock_id_reg  <= sel;
    end
  end

  assign mn0_req_ready  = req_ready_vec[0];
  assign mn1_req_ready  = req_ready_vec[1];
  assign mn2_req_ready  = req_ready_vec[2];
  assign mn3_req_ready  = req_ready_vec[3];
  assign mn0_resp_valid = resp_valid_vec[0];
  assign mn1_resp_valid = resp_valid_vec[1];
  assign mn2_resp_valid = resp_valid_vec[2];
  assign mn3_resp_valid = resp_valid_vec[3];
  assign mn0_resp       = sn_resp;
  assign mn1_resp       = sn_resp;
  assign mn2_resp       = sn_resp;
  assign mn3_resp       = sn_resp;

endmodule
